// File: rtl/byte_to_sample.sv
// Byte stream to 32-bit real/imag sample streams (N real words, then N imag words, little-endian).
// Define BYTE_TO_SAMPLE_STATS_EN to add saturating pkt_cnt/short_cnt/long_cnt outputs.
module byte_to_sample #(
    parameter int N_SAMPLES = 512,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic [DATA_W-1:0] m_real_tdata,
    output logic              m_real_tvalid,
    input  logic              m_real_tready,
    output logic              m_real_tlast,
    output logic [DATA_W-1:0] m_imag_tdata,
    output logic              m_imag_tvalid,
    input  logic              m_imag_tready,
    output logic              m_imag_tlast,
    output logic              err_short,
    output logic              err_long
`ifdef BYTE_TO_SAMPLE_STATS_EN
    ,
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       short_cnt,
    output logic [15:0]       long_cnt
`endif
);

    localparam int CNT_W = $clog2(N_SAMPLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

    typedef enum logic [1:0] {RX_REAL, RX_IMAG, DRAIN} state_t;

    state_t              state_reg, state_next;
    logic [1:0]          byte_ptr_reg, byte_ptr_next;
    logic [DATA_W-9:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]    sample_cnt_reg, sample_cnt_next;
    logic [DATA_W-1:0]   out_data_reg, out_data_next;
    logic                out_valid_reg, out_valid_next;
    logic                out_last_reg, out_last_next;
    logic                out_imag_reg, out_imag_next;
    logic                err_short_reg, err_short_next;
    logic                err_long_reg, err_long_next;
    logic                good_evt;

    logic sel_tready;
    logic accept;
    logic short_evt;

    // The held word remembers its own stream so a drain after a state change is routed correctly.
    assign sel_tready = out_imag_reg ? m_imag_tready : m_real_tready;
    assign accept     = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= RX_REAL;
            byte_ptr_reg   <= 2'd0;
            acc_reg        <= '0;
            sample_cnt_reg <= '0;
            out_data_reg   <= '0;
            out_valid_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
            out_imag_reg   <= 1'b0;
            err_short_reg  <= 1'b0;
            err_long_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            byte_ptr_reg   <= byte_ptr_next;
            acc_reg        <= acc_next;
            sample_cnt_reg <= sample_cnt_next;
            out_data_reg   <= out_data_next;
            out_valid_reg  <= out_valid_next;
            out_last_reg   <= out_last_next;
            out_imag_reg   <= out_imag_next;
            err_short_reg  <= err_short_next;
            err_long_reg   <= err_long_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        byte_ptr_next   = byte_ptr_reg;
        acc_next        = acc_reg;
        sample_cnt_next = sample_cnt_reg;
        out_data_next   = out_data_reg;
        out_valid_next  = out_valid_reg;
        out_last_next   = out_last_reg;
        out_imag_next   = out_imag_reg;
        err_short_next  = 1'b0;
        err_long_next   = 1'b0;
        short_evt       = 1'b0;
        good_evt        = 1'b0;

        if (out_valid_reg && sel_tready) begin
            out_valid_next = 1'b0;
        end

        case (state_reg)
            RX_REAL, RX_IMAG: begin
                if (accept) begin
                    if (byte_ptr_reg != 2'd3) begin
                        acc_next[{byte_ptr_reg, 3'b000} +: 8] = s_axis_tdata;
                        byte_ptr_next = byte_ptr_reg + 2'd1;
                        short_evt     = s_axis_tlast;
                    end else begin
                        out_data_next  = {s_axis_tdata, acc_reg};
                        out_valid_next = 1'b1;
                        out_last_next  = (sample_cnt_reg == LAST_CNT);
                        out_imag_next  = (state_reg == RX_IMAG);
                        byte_ptr_next  = 2'd0;
                        if (sample_cnt_reg == LAST_CNT) begin
                            sample_cnt_next = '0;
                            if (state_reg == RX_REAL) begin
                                state_next = RX_IMAG;
                                short_evt  = s_axis_tlast;
                            end else if (s_axis_tlast) begin
                                state_next = RX_REAL;
                                good_evt   = 1'b1;
                            end else begin
                                state_next = DRAIN;
                            end
                        end else begin
                            sample_cnt_next = sample_cnt_reg + 1'b1;
                            short_evt       = s_axis_tlast;
                        end
                    end
                end
            end
            DRAIN: begin
                if (accept && s_axis_tlast) begin
                    err_long_next = 1'b1;
                    state_next    = RX_REAL;
                end
            end
            default: begin
                state_next = RX_REAL;
            end
        endcase

        // Early tlast: the partial word is dropped and the next packet starts clean.
        if (short_evt) begin
            err_short_next  = 1'b1;
            byte_ptr_next   = 2'd0;
            sample_cnt_next = '0;
            state_next      = RX_REAL;
        end
    end

    always_comb begin
        s_axis_tready = 1'b1;
        if (state_reg != DRAIN) begin
            s_axis_tready = (byte_ptr_reg != 2'd3) || !out_valid_reg || sel_tready;
        end
        m_real_tdata  = out_data_reg;
        m_imag_tdata  = out_data_reg;
        m_real_tvalid = out_valid_reg && !out_imag_reg;
        m_imag_tvalid = out_valid_reg && out_imag_reg;
        m_real_tlast  = out_valid_reg && !out_imag_reg && out_last_reg;
        m_imag_tlast  = out_valid_reg && out_imag_reg && out_last_reg;
        err_short     = err_short_reg;
        err_long      = err_long_reg;
    end

`ifdef BYTE_TO_SAMPLE_STATS_EN
    logic [15:0] pkt_cnt_reg, short_cnt_reg, long_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_reg   <= 16'd0;
            short_cnt_reg <= 16'd0;
            long_cnt_reg  <= 16'd0;
        end else begin
            if (good_evt && pkt_cnt_reg != 16'hFFFF) begin
                pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
            end
            if (err_short_next && short_cnt_reg != 16'hFFFF) begin
                short_cnt_reg <= short_cnt_reg + 16'd1;
            end
            if (err_long_next && long_cnt_reg != 16'hFFFF) begin
                long_cnt_reg <= long_cnt_reg + 16'd1;
            end
        end
    end

    assign pkt_cnt   = pkt_cnt_reg;
    assign short_cnt = short_cnt_reg;
    assign long_cnt  = long_cnt_reg;
`else
    logic unused_good;
    assign unused_good = good_evt;
`endif

endmodule

// File: tb/tb_byte_to_sample.sv
// Directed bench for byte_to_sample with N_SAMPLES=4: good, backpressure, short, long and mid-packet reset.
module tb_byte_to_sample;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_axis_tdata = 8'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [31:0] m_real_tdata;
    logic        m_real_tvalid;
    logic        m_real_tready = 1'b1;
    logic        m_real_tlast;
    logic [31:0] m_imag_tdata;
    logic        m_imag_tvalid;
    logic        m_imag_tready = 1'b1;
    logic        m_imag_tlast;
    logic        err_short;
    logic        err_long;
`ifdef BYTE_TO_SAMPLE_STATS_EN
    logic [15:0] pkt_cnt, short_cnt, long_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] real_q[$];
    logic [31:0] imag_q[$];
    bit          real_l_q[$];
    bit          imag_l_q[$];
    int          err_s_cnt = 0;
    int          err_l_cnt = 0;
    bit          overlap_seen = 1'b0;

    always #5 clk = ~clk;

    byte_to_sample #(.N_SAMPLES(N), .DATA_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_real_tdata  (m_real_tdata),
        .m_real_tvalid (m_real_tvalid),
        .m_real_tready (m_real_tready),
        .m_real_tlast  (m_real_tlast),
        .m_imag_tdata  (m_imag_tdata),
        .m_imag_tvalid (m_imag_tvalid),
        .m_imag_tready (m_imag_tready),
        .m_imag_tlast  (m_imag_tlast),
        .err_short     (err_short),
        .err_long      (err_long)
`ifdef BYTE_TO_SAMPLE_STATS_EN
        ,
        .pkt_cnt       (pkt_cnt),
        .short_cnt     (short_cnt),
        .long_cnt      (long_cnt)
`endif
    );

    // Output monitor: handshakes seen at the falling edge complete on the following rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_real_tvalid && m_real_tready) begin
                real_q.push_back(m_real_tdata);
                real_l_q.push_back(m_real_tlast);
            end
            if (m_imag_tvalid && m_imag_tready) begin
                imag_q.push_back(m_imag_tdata);
                imag_l_q.push_back(m_imag_tlast);
            end
            if (err_short) err_s_cnt++;
            if (err_long) err_l_cnt++;
            if (m_real_tvalid && m_imag_tvalid) overlap_seen = 1'b1;
        end
    end

    function automatic logic [31:0] exp_word(input logic [7:0] base, input int idx);
        logic [7:0] b0, b1, b2, b3;
        b0 = 8'(int'(base) + 4 * idx);
        b1 = 8'(int'(base) + 4 * idx + 1);
        b2 = 8'(int'(base) + 4 * idx + 2);
        b3 = 8'(int'(base) + 4 * idx + 3);
        return {b3, b2, b1, b0};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        real_q.delete();
        imag_q.delete();
        real_l_q.delete();
        imag_l_q.delete();
        err_s_cnt = 0;
        err_l_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int n;
        bit ok;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = s_axis_tready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: byte %h not accepted within 200 cycles, want accepted", d);
        end
    endtask

    task automatic send_pkt(input int nbytes, input logic [7:0] base);
        for (int k = 0; k < nbytes; k++) begin
            send_byte(8'(int'(base) + k), k == nbytes - 1);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_real_tvalid, m_imag_tvalid, m_real_tlast, m_imag_tlast} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_valid_last: got %b want 0000", {m_real_tvalid, m_imag_tvalid, m_real_tlast, m_imag_tlast});
        end
        checks++;
        if (m_real_tdata !== 32'd0 || m_imag_tdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_tdata: got %h/%h want 0/0", m_real_tdata, m_imag_tdata);
        end
        checks++;
        if ({err_short, err_long} !== 2'b00) begin
            errors++;
            $display("FAIL reset_err: got %b want 00", {err_short, err_long});
        end
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_tready: got %b want 1", s_axis_tready);
        end
        $display("test_reset done");
    endtask

    task automatic check_full_pkt(input string name, input logic [7:0] base);
        checks++;
        if (real_q.size() != N || imag_q.size() != N) begin
            errors++;
            $display("FAIL %s_count: got real=%0d imag=%0d want %0d/%0d", name, real_q.size(), imag_q.size(), N, N);
        end
        for (int i = 0; i < N && i < real_q.size(); i++) begin
            checks++;
            if (real_q[i] !== exp_word(base, i) || real_l_q[i] !== (i == N - 1)) begin
                errors++;
                $display("FAIL %s_real%0d: got %h last=%b want %h last=%b", name, i, real_q[i], real_l_q[i], exp_word(base, i), i == N - 1);
            end
        end
        for (int i = 0; i < N && i < imag_q.size(); i++) begin
            checks++;
            if (imag_q[i] !== exp_word(base, N + i) || imag_l_q[i] !== (i == N - 1)) begin
                errors++;
                $display("FAIL %s_imag%0d: got %h last=%b want %h last=%b", name, i, imag_q[i], imag_l_q[i], exp_word(base, N + i), i == N - 1);
            end
        end
    endtask

    task automatic test_good();
        clear_mon();
        send_pkt(32, 8'h00);
        idle(8);
        check_full_pkt("good", 8'h00);
        checks++;
        if (real_q.size() != N || real_q[0] !== 32'h03020100 || real_q[N-1] !== 32'h0F0E0D0C) begin
            errors++;
            $display("FAIL good_real_const: got size %0d want 03020100..0F0E0D0C", real_q.size());
        end
        checks++;
        if (imag_q.size() != N || imag_q[0] !== 32'h13121110 || imag_q[N-1] !== 32'h1F1E1D1C) begin
            errors++;
            $display("FAIL good_imag_const: got size %0d want 13121110..1F1E1D1C", imag_q.size());
        end
        checks++;
        if (err_s_cnt != 0 || err_l_cnt != 0) begin
            errors++;
            $display("FAIL good_err: got short=%0d long=%0d want 0/0", err_s_cnt, err_l_cnt);
        end
        $display("test_good done: real=%0d imag=%0d", real_q.size(), imag_q.size());
    endtask

    task automatic test_backpressure();
        bit stall_seen;
        int n;
        clear_mon();
        stall_seen    = 1'b0;
        m_real_tready = 1'b0;
        fork
            send_pkt(32, 8'h80);
            begin
                n = 0;
                while (!m_real_tvalid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                checks++;
                if (m_real_tvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_first_valid: got %b want 1", m_real_tvalid);
                end
                repeat (10) begin
                    @(negedge clk);
                    checks++;
                    if (m_real_tvalid !== 1'b1 || m_real_tdata !== 32'h83828180 || m_real_tlast !== 1'b0) begin
                        errors++;
                        $display("FAIL bp_hold: got v=%b %h l=%b want v=1 83828180 l=0", m_real_tvalid, m_real_tdata, m_real_tlast);
                    end
                    if (!s_axis_tready) stall_seen = 1'b1;
                end
                @(posedge clk);
                #1;
                m_real_tready = 1'b1;
            end
        join
        idle(8);
        checks++;
        if (stall_seen !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall: got s_axis_tready never low, want a stall");
        end
        check_full_pkt("bp", 8'h80);
        $display("test_backpressure done: real=%0d imag=%0d", real_q.size(), imag_q.size());
    endtask

    task automatic test_short();
        clear_mon();
        send_pkt(14, 8'h00);
        idle(8);
        checks++;
        if (real_q.size() != 3 || imag_q.size() != 0) begin
            errors++;
            $display("FAIL short_count: got real=%0d imag=%0d want 3/0", real_q.size(), imag_q.size());
        end
        for (int i = 0; i < 3 && i < real_q.size(); i++) begin
            checks++;
            if (real_q[i] !== exp_word(8'h00, i) || real_l_q[i] !== 1'b0) begin
                errors++;
                $display("FAIL short_real%0d: got %h last=%b want %h last=0", i, real_q[i], real_l_q[i], exp_word(8'h00, i));
            end
        end
        checks++;
        if (err_s_cnt != 1 || err_l_cnt != 0) begin
            errors++;
            $display("FAIL short_err: got short=%0d long=%0d want 1/0", err_s_cnt, err_l_cnt);
        end
        clear_mon();
        send_pkt(32, 8'h40);
        idle(8);
        check_full_pkt("after_short", 8'h40);
        $display("test_short done");
    endtask

    task automatic test_long();
        clear_mon();
        send_pkt(36, 8'h00);
        idle(8);
        check_full_pkt("long", 8'h00);
        checks++;
        if (err_l_cnt != 1 || err_s_cnt != 0) begin
            errors++;
            $display("FAIL long_err: got long=%0d short=%0d want 1/0", err_l_cnt, err_s_cnt);
        end
        $display("test_long done");
    endtask

    task automatic test_reset_mid();
        clear_mon();
        for (int k = 0; k < 10; k++) send_byte(8'(k), 1'b0);
        s_axis_tvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({m_real_tvalid, m_imag_tvalid, m_real_tlast, m_imag_tlast, err_short, err_long} !== 6'd0) begin
            errors++;
            $display("FAIL rstmid_ctrl: got %b want 000000", {m_real_tvalid, m_imag_tvalid, m_real_tlast, m_imag_tlast, err_short, err_long});
        end
        checks++;
        if (m_real_tdata !== 32'd0 || m_imag_tdata !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_tdata: got %h/%h want 0/0", m_real_tdata, m_imag_tdata);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_mon();
        send_pkt(32, 8'hA0);
        idle(8);
        check_full_pkt("rstmid", 8'hA0);
        checks++;
        if (err_s_cnt != 0 || err_l_cnt != 0) begin
            errors++;
            $display("FAIL rstmid_err: got short=%0d long=%0d want 0/0", err_s_cnt, err_l_cnt);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_exclusive();
        checks++;
        if (overlap_seen !== 1'b0) begin
            errors++;
            $display("FAIL exclusive_valid: got both tvalids high, want never");
        end
        $display("test_exclusive done");
    endtask

`ifdef BYTE_TO_SAMPLE_STATS_EN
    task automatic test_stats();
        @(negedge clk);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_pkt(32, 8'h00);
        send_pkt(32, 8'h10);
        send_pkt(14, 8'h20);
        send_pkt(36, 8'h30);
        idle(8);
        checks++;
        if (pkt_cnt !== 16'd2 || short_cnt !== 16'd1 || long_cnt !== 16'd1) begin
            errors++;
            $display("FAIL stats: got pkt=%0d short=%0d long=%0d want 2/1/1", pkt_cnt, short_cnt, long_cnt);
        end
        $display("test_stats done");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_good();
        test_backpressure();
        test_short();
        test_long();
        test_reset_mid();
        test_exclusive();
`ifdef BYTE_TO_SAMPLE_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
